// File: rtl/fball_pkg.sv
// Shared types and constants for the fireball controller.
package fball_pkg;

  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned SPRITE_DIM_DEF = 21;
  localparam int unsigned LIFETIME_TICKS = 120;

  typedef enum logic {
    StIdle,
    StFly
  } fball_state_e;

  // Animation frame order; the value drives the sprite-memory mux directly.
  typedef enum logic [1:0] {
    FrmDown  = 2'd0,
    FrmLeft  = 2'd1,
    FrmUp    = 2'd2,
    FrmRight = 2'd3
  } frame_sel_e;

  // Next animation frame, wrapping 3 -> 0.
  function automatic logic [1:0] next_frame(input logic [1:0] f);
    return f + 2'd1;
  endfunction

endpackage

// File: rtl/fball_addr_gen.sv
// Fireball box test and sprite address generation, registered one clock after DrawX/DrawY.
module fball_addr_gen
  import fball_pkg::*;
#(
  parameter int unsigned SPRITE_DIM = SPRITE_DIM_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_active,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [9:0] i_draw_x,
  input  logic [9:0] i_draw_y,
  output logic       o_on,
  output logic [8:0] o_addr
);

  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic       w_in_x;
  logic       w_in_y;
  logic       w_on;
  logic [8:0] w_addr;

  assign w_dx = i_draw_x - i_x;
  assign w_dy = i_draw_y - i_y;

  // Offset below SPRITE_DIM is the same as DrawX <= x+SPRITE_DIM-1 once DrawX >= x.
  assign w_in_x = (i_draw_x >= i_x) && (w_dx < 10'(SPRITE_DIM));
  assign w_in_y = (i_draw_y >= i_y) && (w_dy < 10'(SPRITE_DIM));
  assign w_on   = i_active && w_in_x && w_in_y;

  // In-box results never exceed 440, so 9-bit modular arithmetic is exact.
  assign w_addr = 9'(w_dy) * 9'(SPRITE_DIM) + 9'(w_dx);

  // Register the pixel hit and address.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      o_on   <= 1'b0;
      o_addr <= '0;
    end else begin
      o_on   <= w_on;
      o_addr <= w_on ? w_addr : 9'd0;
    end
  end

endmodule

// File: rtl/fball_ctrl.sv
// Fireball controller: launch, per-frame motion with floor bounce, animation and
// pixel lookup. Optional macro FBALL_LIFETIME_EN adds a 120-tick despawn timer.
module fball_ctrl
  import fball_pkg::*;
#(
  parameter int unsigned SPRITE_DIM = SPRITE_DIM_DEF,
  parameter int unsigned X_STEP     = 4,
  parameter int unsigned Y_STEP     = 2,
  parameter int unsigned RISE_TICKS = 6,
  parameter int unsigned FLOOR_Y    = 400,
  parameter int unsigned ANIM_DIV   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire_req,
  input  logic       facing_left,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       busy,
  output logic       fball_on,
  output logic [8:0] read_address,
  output logic [1:0] frame_sel
);

  localparam int unsigned RiseW = $clog2(RISE_TICKS + 1);
  localparam int unsigned AnimW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  fball_state_e     r_state;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_dir;
  logic [RiseW-1:0] r_rise_cnt;
  logic [AnimW-1:0] r_anim_cnt;
  logic [1:0]       r_frame_sel;
  logic             r_fclk_prev;

  logic             w_tick;
  logic             w_exit;
  logic             w_life_end;
  logic [10:0]      w_x_right;
  logic [10:0]      w_y_down;

  assign w_tick    = frame_clk & ~r_fclk_prev;
  assign w_x_right = {1'b0, r_x} + 11'(SPRITE_DIM) + 11'(X_STEP);
  assign w_exit    = r_dir ? (r_x < 10'(X_STEP)) : (w_x_right > 11'(SCREEN_W));
  assign w_y_down  = {1'b0, r_y} + 11'(Y_STEP);

`ifdef FBALL_LIFETIME_EN
  logic [6:0] r_life_cnt;

  assign w_life_end = (r_life_cnt == 7'(LIFETIME_TICKS - 1));

  // Count motion ticks since launch; cleared on spawn.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_life_cnt <= '0;
    end else if (r_state == StIdle) begin
      if (fire_req) r_life_cnt <= '0;
    end else if (w_tick && !w_exit && !w_life_end) begin
      r_life_cnt <= r_life_cnt + 7'd1;
    end
  end
`else
  assign w_life_end = 1'b0;
`endif

  // Flight FSM: launch, motion, bounce, animation and despawn.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= StIdle;
      r_x         <= '0;
      r_y         <= '0;
      r_dir       <= 1'b0;
      r_rise_cnt  <= '0;
      r_anim_cnt  <= '0;
      r_frame_sel <= FrmDown;
      r_fclk_prev <= 1'b0;
    end else begin
      r_fclk_prev <= frame_clk;
      unique case (r_state)
        StIdle: begin
          // A coincident tick is dropped: launch values only this cycle.
          if (fire_req) begin
            r_state     <= StFly;
            r_x         <= spawn_x;
            r_y         <= spawn_y;
            r_dir       <= facing_left;
            r_rise_cnt  <= '0;
            r_anim_cnt  <= '0;
            r_frame_sel <= FrmDown;
          end
        end
        StFly: begin
          if (w_tick) begin
            if (w_exit || w_life_end) begin
              r_state <= StIdle;
            end else begin
              r_x <= r_dir ? (r_x - 10'(X_STEP)) : (r_x + 10'(X_STEP));
              if (r_rise_cnt != '0) begin
                r_y        <= r_y - 10'(Y_STEP);
                r_rise_cnt <= r_rise_cnt - RiseW'(1);
              end else if (w_y_down >= 11'(FLOOR_Y)) begin
                r_y        <= 10'(FLOOR_Y);
                r_rise_cnt <= RiseW'(RISE_TICKS);
              end else begin
                r_y <= w_y_down[9:0];
              end
              if (r_anim_cnt == AnimW'(ANIM_DIV - 1)) begin
                r_anim_cnt  <= '0;
                r_frame_sel <= next_frame(r_frame_sel);
              end else begin
                r_anim_cnt <= r_anim_cnt + AnimW'(1);
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = (r_state == StFly);
  assign frame_sel = r_frame_sel;

  fball_addr_gen #(
    .SPRITE_DIM(SPRITE_DIM)
  ) u_addr_gen (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_active(busy),
    .i_x     (r_x),
    .i_y     (r_y),
    .i_draw_x(DrawX),
    .i_draw_y(DrawY),
    .o_on    (fball_on),
    .o_addr  (read_address)
  );

endmodule

// File: tb/tb_fball_ctrl.sv
// Self-checking bench for fball_ctrl: behavioural model plus directed literal checks.
module tb_fball_ctrl;

  localparam int Dim   = 21;
  localparam int XStep = 4;
  localparam int YStep = 2;
  localparam int Rise  = 6;
  localparam int Floor = 400;
  localparam int Anim  = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       fire_req = 1'b0;
  logic       facing_left = 1'b0;
  logic [9:0] spawn_x = '0;
  logic [9:0] spawn_y = '0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       busy;
  logic       fball_on;
  logic [8:0] read_address;
  logic [1:0] frame_sel;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  bit m_busy = 0, m_dir = 0, m_prev = 0;
  int m_x = 0, m_y = 0, m_rise = 0, m_ticks = 0, m_life = 0;
  int e_on = 0, e_addr = 0;

  always #5 Clk = ~Clk;

  fball_ctrl #(
    .SPRITE_DIM(Dim),
    .X_STEP    (XStep),
    .Y_STEP    (YStep),
    .RISE_TICKS(Rise),
    .FLOOR_Y   (Floor),
    .ANIM_DIV  (Anim)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .fire_req    (fire_req),
    .facing_left (facing_left),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .busy        (busy),
    .fball_on    (fball_on),
    .read_address(read_address),
    .frame_sel   (frame_sel)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model, advanced at each rising edge from the rules of motion.
  always @(posedge Clk) begin
    bit tick;
    bit leave;
    if (!Reset) begin
      e_on = 0; e_addr = 0;
      m_busy = 0; m_dir = 0; m_prev = 0;
      m_x = 0; m_y = 0; m_rise = 0; m_ticks = 0; m_life = 0;
    end else begin
      e_on = (m_busy && int'(DrawX) >= m_x && int'(DrawX) <= m_x + Dim - 1 &&
              int'(DrawY) >= m_y && int'(DrawY) <= m_y + Dim - 1) ? 1 : 0;
      e_addr = e_on ? (int'(DrawY) - m_y) * Dim + (int'(DrawX) - m_x) : 0;
      tick = frame_clk && !m_prev;
      m_prev = frame_clk;
      if (!m_busy) begin
        if (fire_req) begin
          m_busy = 1; m_x = int'(spawn_x); m_y = int'(spawn_y); m_dir = facing_left;
          m_rise = 0; m_ticks = 0; m_life = 0;
        end
      end else if (tick) begin
        leave = m_dir ? (m_x < XStep) : (m_x + Dim + XStep > 640);
`ifdef FBALL_LIFETIME_EN
        if (m_life + 1 == 120) leave = 1;
`endif
        if (leave) begin
          m_busy = 0;
        end else begin
          m_x = m_dir ? m_x - XStep : m_x + XStep;
          if (m_rise > 0) begin
            m_y -= YStep; m_rise--;
          end else begin
            m_y += YStep;
            if (m_y >= Floor) begin m_y = Floor; m_rise = Rise; end
          end
          m_ticks++;
          m_life++;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("frame_sel", int'(frame_sel), (m_ticks / Anim) % 4);
      chk("fball_on", int'(fball_on), e_on);
      chk("read_address", int'(read_address), e_addr);
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1; step();
      frame_clk = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0; fire_req = 1'b0; frame_clk = 1'b0;
    step(); step(); step();
    Reset = 1'b1;
  endtask

  task automatic launch(input int x, input int y, input bit left);
    spawn_x = 10'(x); spawn_y = 10'(y); facing_left = left; fire_req = 1'b1;
    step();
    fire_req = 1'b0;
  endtask

  // Probe a pixel and check the registered result one clock later.
  task automatic probe(input string name, input int dx, input int dy, input int on, input int addr);
    DrawX = 10'(dx); DrawY = 10'(dy);
    step();
    @(negedge Clk);
    chk({name, "_on"}, int'(fball_on), on);
    chk({name, "_addr"}, int'(read_address), addr);
    #1;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    do_reset();
    @(negedge Clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame", int'(frame_sel), 0);

    // Launch on the first cycle after reset release, then one tick.
    #1;
    launch(100, 300, 1'b0);
    @(negedge Clk);
    chk("launch_busy", int'(busy), 1);
    #1;
    tick_n(1);
    probe("launch_pos", 104, 302, 1, 0);
    probe("launch_left", 103, 302, 0, 0);

    // Reset held during flight.
    Reset = 1'b0; step(); step(); step(); Reset = 1'b1;
    @(negedge Clk);
    chk("rst_fly_busy", int'(busy), 0);
    chk("rst_fly_on", int'(fball_on), 0);
    chk("rst_fly_addr", int'(read_address), 0);
    chk("rst_fly_frame", int'(frame_sel), 0);
    #1;

    // Address corner and just outside.
    launch(100, 300, 1'b0);
    probe("addr_corner", 120, 320, 1, 440);
    probe("addr_outside", 121, 320, 0, 0);
    probe("addr_mid", 105, 302, 1, 47);

    // Floor bounce.
    do_reset();
    launch(100, 398, 1'b0);
    tick_n(1);
    probe("bounce_floor", 104, 400, 1, 0);
    probe("bounce_above", 104, 399, 0, 0);
    tick_n(6);
    probe("bounce_top", 128, 388, 1, 0);
    probe("bounce_top_above", 128, 387, 0, 0);
    tick_n(1);
    probe("bounce_fall", 132, 390, 1, 0);

    // Animation sequence.
    do_reset();
    launch(100, 100, 1'b0);
    @(negedge Clk); chk("anim_t0", int'(frame_sel), 0); #1;
    tick_n(4); @(negedge Clk); chk("anim_t4", int'(frame_sel), 1); #1;
    tick_n(4); @(negedge Clk); chk("anim_t8", int'(frame_sel), 2); #1;
    tick_n(4); @(negedge Clk); chk("anim_t12", int'(frame_sel), 3); #1;
    tick_n(4); @(negedge Clk); chk("anim_t16", int'(frame_sel), 0); #1;

    // Left exit, with an ignored fire_req during flight.
    do_reset();
    launch(11, 200, 1'b1);
    tick_n(2);
    launch(300, 300, 1'b0);
    probe("exit_pos", 3, 204, 1, 0);
    tick_n(1);
    @(negedge Clk); chk("exit_busy", int'(busy), 0); #1;

    // Spawn wins over a coincident tick in IDLE.
    spawn_x = 10'd50; spawn_y = 10'd50; facing_left = 1'b0;
    fire_req = 1'b1; frame_clk = 1'b1;
    step();
    fire_req = 1'b0; frame_clk = 1'b0;
    probe("spawn_prec", 50, 50, 1, 0);

    // Randomized traffic.
    for (int c = 0; c < 6000; c++) begin
      Reset = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      fire_req = ($urandom_range(0, 19) == 0);
      facing_left = 1'($urandom_range(0, 1));
      spawn_x = 10'($urandom_range(0, 639));
      spawn_y = 10'($urandom_range(0, 450));
      if ($urandom_range(0, 1) == 0) begin
        DrawX = 10'((m_x + int'($urandom_range(0, 24)) + 1022) % 1024);
        DrawY = 10'((m_y + int'($urandom_range(0, 24)) + 1022) % 1024);
      end else begin
        DrawX = 10'($urandom_range(0, 1023));
        DrawY = 10'($urandom_range(0, 1023));
      end
      step();
    end

    Reset = 1'b1;
    step();
    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
